// File: rtl/bpsk_modulator.sv
// -----------------------------------------------------------------------------
// bpsk_modulator
//   BPSK transmitter. Bytes arrive over a valid/ready handshake into a one-deep
//   holding register and are serialised MSB first. Each bit keys the sign of an
//   NCO sine carrier: bit 1 sends +sin and bit 0 sends -sin. The signed sample
//   is also provided as offset binary for an 8-bit DAC.
//
// Parameters
//   SAMPLES_PER_SYM  clocks per symbol (>= 2)
//   AMP              peak sine amplitude (1..127)
//
// Ports
//   sys_clk     in   clock, all logic on the rising edge
//   sys_rst_n   in   asynchronous active-low reset
//   fcw         in   32-bit carrier phase increment per clock
//   tx_en       in   enables accepting and starting bytes
//   byte_data   in   byte to send (MSB first)
//   byte_valid  in   byte_data valid
//   byte_ready  out  holding register can take a byte
//   busy        out  a byte is being sent
//   sym_strobe  out  one-cycle pulse on the first cycle of each symbol
//   bit_out     out  bit currently being sent
//   mod_out     out  signed modulated sample, -AMP..+AMP
//   da_data     out  mod_out + 128 (offset binary)
// -----------------------------------------------------------------------------
module bpsk_modulator #(
    parameter int SAMPLES_PER_SYM = 32,
    parameter int AMP             = 127
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic [31:0] fcw,
    input  logic        tx_en,
    input  logic [7:0]  byte_data,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic        busy,
    output logic        sym_strobe,
    output logic        bit_out,
    output logic [7:0]  mod_out,
    output logic [7:0]  da_data
);

    localparam int CNT_W = (SAMPLES_PER_SYM > 2) ? $clog2(SAMPLES_PER_SYM) : 1;
    localparam logic [CNT_W-1:0] SYM_LAST = CNT_W'(SAMPLES_PER_SYM - 1);
    localparam real TWO_PI = 6.283185307179586;

    typedef enum logic {IDLE, SEND} state_t;

    // Taylor series for sin(x), accurate far beyond 8-bit resolution on [0, pi/2].
    function automatic real sin_poly(input real x);
        real term;
        real sum;
        term = x;
        sum  = x;
        for (int n = 1; n <= 9; n++) begin
            term = -term * x * x / real'((2 * n) * (2 * n + 1));
            sum  = sum + term;
        end
        return sin_poly_ret(sum);
    endfunction

    function automatic real sin_poly_ret(input real v);
        return v;
    endfunction

    // Round half away from zero; argument is never negative here.
    function automatic int round_pos(input real v);
        return $rtoi(v + 0.5);
    endfunction

    // Entry k = round(AMP*sin(2*pi*k/256)), built from the first quadrant by
    // symmetry so the zero crossings and peaks are exact.
    function automatic int sine_entry(input int k);
        int q;
        int r;
        q = k % 128;
        if (q > 64) q = 128 - q;
        r = round_pos(real'(AMP) * sin_poly(TWO_PI * real'(q) / 256.0));
        return (k >= 128) ? -r : r;
    endfunction

    logic signed [7:0] sin_lut [256];

    for (genvar k = 0; k < 256; k++) begin : g_lut
        localparam int V = sine_entry(k);
        assign sin_lut[k] = 8'(V);
    end

    state_t            state_q, state_d;
    logic [31:0]       acc_q, acc_d;
    logic signed [7:0] sin_q, sin_d;
    logic              act_q, act_d;
    logic              bit_dly_q, bit_dly_d;
    logic signed [7:0] mod_q, mod_d;
    logic [7:0]        hold_q, hold_d;
    logic              hold_full_q, hold_full_d;
    logic [7:0]        shreg_q, shreg_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [CNT_W-1:0]  sym_cnt_q, sym_cnt_d;
    logic              strobe_q, strobe_d;
    logic              rdy_en_q, rdy_en_d;
    logic              load;

    // Keeps byte_ready low while reset is held and for the first edge after.
    assign byte_ready = tx_en & ~hold_full_q & rdy_en_q;
    assign busy       = (state_q == SEND);
    assign sym_strobe = strobe_q;
    assign bit_out    = shreg_q[7];
    assign mod_out    = mod_q;
    // Adding 128 to an 8-bit two's-complement value is just an MSB flip.
    assign da_data    = {~mod_q[7], mod_q[6:0]};

    always_comb begin
        rdy_en_d  = 1'b1;
        acc_d     = acc_q + fcw;
        // Stage 1: LUT lookup, with symbol activity and bit delayed to match.
        sin_d     = sin_lut[acc_q[31:24]];
        act_d     = busy;
        bit_dly_d = bit_out;
        // Stage 2: sign keying; -sin_q cannot overflow since |sin_q| <= 127.
        mod_d     = act_q ? (bit_dly_q ? sin_q : -sin_q) : 8'sd0;
    end

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        shreg_d     = shreg_q;
        bit_idx_d   = bit_idx_q;
        sym_cnt_d   = sym_cnt_q;
        strobe_d    = 1'b0;
        load        = 1'b0;

        if (byte_valid && byte_ready) begin
            hold_d      = byte_data;
            hold_full_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (hold_full_q && tx_en) load = 1'b1;
            end
            SEND: begin
                if (sym_cnt_q == SYM_LAST) begin
                    if (bit_idx_q != 3'd0) begin
                        bit_idx_d = bit_idx_q - 3'd1;
                        shreg_d   = {shreg_q[6:0], 1'b0};
                        sym_cnt_d = '0;
                        strobe_d  = 1'b1;
                    end else if (hold_full_q && tx_en) begin
                        load = 1'b1;
                    end else begin
                        state_d   = IDLE;
                        sym_cnt_d = '0;
                    end
                end else begin
                    sym_cnt_d = sym_cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // byte_ready is low while hold_full, so a load never meets an accept.
        if (load) begin
            state_d     = SEND;
            shreg_d     = hold_q;
            hold_full_d = 1'b0;
            bit_idx_d   = 3'd7;
            sym_cnt_d   = '0;
            strobe_d    = 1'b1;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            sin_q       <= '0;
            act_q       <= 1'b0;
            bit_dly_q   <= 1'b0;
            mod_q       <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            shreg_q     <= '0;
            bit_idx_q   <= '0;
            sym_cnt_q   <= '0;
            strobe_q    <= 1'b0;
            rdy_en_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            sin_q       <= sin_d;
            act_q       <= act_d;
            bit_dly_q   <= bit_dly_d;
            mod_q       <= mod_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            shreg_q     <= shreg_d;
            bit_idx_q   <= bit_idx_d;
            sym_cnt_q   <= sym_cnt_d;
            strobe_q    <= strobe_d;
            rdy_en_q    <= rdy_en_d;
        end
    end

endmodule

// File: tb/tb_bpsk_modulator.sv
// -----------------------------------------------------------------------------
// tb_bpsk_modulator
//   Scoreboard bench for bpsk_modulator. Stimulus pushes the expected bit
//   sequence of every byte it hands over; a monitor pops one entry per
//   sym_strobe and checks bit_out, strobe spacing, busy and the modulated
//   sample two cycles later against a hand-computed sine table.
// -----------------------------------------------------------------------------
module tb_bpsk_modulator;

    localparam int SPS = 32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] fcw = '0;
    logic        tx_en = 1'b0;
    logic [7:0]  byte_data = '0;
    logic        byte_valid = 1'b0;
    logic        byte_ready, busy, sym_strobe, bit_out;
    logic [7:0]  mod_out, da_data;

    bpsk_modulator #(.SAMPLES_PER_SYM(SPS), .AMP(127)) dut (
        .sys_clk(clk), .sys_rst_n(rst_n), .fcw(fcw), .tx_en(tx_en),
        .byte_data(byte_data), .byte_valid(byte_valid), .byte_ready(byte_ready),
        .busy(busy), .sym_strobe(sym_strobe), .bit_out(bit_out),
        .mod_out(mod_out), .da_data(da_data)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic b;
        logic cont;   // strobe must follow the previous one by exactly SPS
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   nstrobes = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Hand table: with fcw a multiple of 2^30 starting from acc=0 only these
    // four LUT addresses occur.
    function automatic int hand_sin(input logic [7:0] idx);
        case (idx)
            8'd0:    return 0;
            8'd64:   return 127;
            8'd128:  return 0;
            8'd192:  return -127;
            default: return -999;
        endcase
    endfunction

    logic [31:0] bacc;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) bacc <= '0;
        else        bacc <= bacc + fcw;
    end

    // Monitor
    initial begin : monitor
        int   cyc, last_cyc, rem, emod;
        bit   have_last, mbit;
        bit   d1_act, d2_act, d1_bit, d2_bit;
        logic [7:0] d1_idx, d2_idx;
        exp_t e;
        cyc = 0; last_cyc = 0; rem = 0; have_last = 0; mbit = 0;
        d1_act = 0; d2_act = 0; d1_bit = 0; d2_bit = 0; d1_idx = 0; d2_idx = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                cyc = 0; rem = 0; have_last = 0;
                d1_act = 0; d2_act = 0;
            end else begin
                cyc++;
                if (sym_strobe) begin
                    nstrobes++;
                    if (q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_strobe: got strobe expected none at %0t", $time);
                    end else begin
                        e = q.pop_front();
                        check("bit_out", int'(bit_out), int'(e.b));
                        if (e.cont)
                            check("strobe_gap", have_last ? cyc - last_cyc : -1, SPS);
                        mbit = e.b;
                        rem  = SPS;
                    end
                    last_cyc  = cyc;
                    have_last = 1;
                end
                emod = d2_act ? (d2_bit ? hand_sin(d2_idx) : -hand_sin(d2_idx)) : 0;
                check("mod_out", int'($signed(mod_out)), emod);
                check("da_data", int'(da_data), (emod + 128) & 255);
                check("busy", int'(busy), (rem > 0) ? 1 : 0);
                d2_act = d1_act; d2_bit = d1_bit; d2_idx = d1_idx;
                d1_act = (rem > 0); d1_bit = mbit; d1_idx = bacc[31:24];
                if (rem > 0) rem--;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit cont);
        bit ok;
        ok = 0;
        @(negedge clk);
        byte_data  = b;
        byte_valid = 1'b1;
        for (int i = 7; i >= 0; i--) q.push_back('{b[i], (i == 7) ? cont : 1'b1});
        for (int n = 0; n < 2000; n++) begin
            if (byte_ready) begin ok = 1; break; end
            @(negedge clk);
        end
        check("accept_timeout", int'(ok), 1);
        @(posedge clk);
        #1 byte_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 0;
        for (int n = 0; n < 10 && !busy; n++) @(negedge clk);
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            if (!busy) begin ok = 1; break; end
        end
        check("idle_timeout", int'(ok), 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_da"}, int'(da_data), 128);
        check({tag, "_mod"}, int'($signed(mod_out)), 0);
        check({tag, "_ready"}, int'(byte_ready), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_strobe"}, int'(sym_strobe), 0);
        check({tag, "_bit"}, int'(bit_out), 0);
    endtask

    initial begin : stimulus
        int n0;
        // Reset with tx_en already high
        tx_en = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 check_reset_outputs("rst");
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("ready_after_release", int'(byte_ready), 1);

        // fcw=0 from reset: carrier stays at LUT[0]=0
        send_byte(8'hFF, 1'b0);
        wait_idle();

        // Single byte on a quarter-rate carrier
        @(negedge clk);
        fcw = 32'h4000_0000;
        send_byte(8'hA5, 1'b0);
        wait_idle();
        repeat (10) @(negedge clk);

        // Back-to-back bytes, second one accepted during the first
        send_byte(8'hFF, 1'b0);
        send_byte(8'h00, 1'b1);
        wait_idle();
        repeat (5) @(negedge clk);

        // tx_en dropped mid-byte with a byte held
        send_byte(8'h3C, 1'b0);
        send_byte(8'hC3, 1'b0);
        repeat (3 * SPS + 4) @(negedge clk);
        tx_en = 1'b0;
        @(negedge clk);
        check("ready_txen_low", int'(byte_ready), 0);
        wait_idle();
        repeat (20) @(negedge clk);
        check("held_not_started", int'(busy), 0);
        check("ready_still_low", int'(byte_ready), 0);
        tx_en = 1'b1;
        @(negedge clk);
        check("held_start", int'(sym_strobe), 1);
        wait_idle();
        repeat (5) @(negedge clk);

        // Reset pulsed in the middle of a byte
        send_byte(8'hA5, 1'b0);
        repeat (5 * SPS + 6) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("midrst");
        q.delete();
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        n0 = nstrobes;
        repeat (300) @(negedge clk);
        check("no_residual_strobes", nstrobes - n0, 0);
        check("post_rst_busy", int'(busy), 0);

        check("queue_empty", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
